// File: rtl/mul_ctrl.sv
// Control sequencer for the repeated-addition multiplier: accepts operand pairs,
// drives the datapath load/add/decrement strobes and holds the result handshake.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for an operand pair, req_ready high
//   LOAD_A | opa on data_in, LdA pulsed
//   LOAD_B | opb on data_in, LdB + clrP pulsed
//   ADD    | one LdP + decB per cycle until the datapath B counter hits zero
//   DONE   | product final in datapath P, res_valid held until res_ready
module mul_ctrl #(
    parameter int W        = 16,
    parameter bit SWAP_MIN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic         abort,
    input  logic         eqz,
    output logic [W-1:0] data_in,
    output logic         LdA,
    output logic         LdB,
    output logic         LdP,
    output logic         clrP,
    output logic         decB,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         busy,
    output logic [W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_ADD    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    state_t       r_state;
    logic [W-1:0] r_opa;
    logic [W-1:0] r_opb;
    logic [W-1:0] r_iter;
    logic         w_swap;

    // Loading the smaller operand into B minimises the number of add cycles.
    assign w_swap = SWAP_MIN && (req_a < req_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_iter  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_opa   <= w_swap ? req_b : req_a;
                        r_opb   <= w_swap ? req_a : req_b;
                        r_iter  <= '0;
                        r_state <= S_LOAD_A;
                    end
                end
                S_LOAD_A: r_state <= abort ? S_IDLE : S_LOAD_B;
                S_LOAD_B: r_state <= abort ? S_IDLE : S_ADD;
                S_ADD: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (eqz) begin
                        r_state <= S_DONE;
                    end else begin
                        r_iter <= r_iter + ONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from state; ADD is Mealy on eqz, abort blanks everything.
    always_comb begin
        data_in = '0;
        LdA     = 1'b0;
        LdB     = 1'b0;
        LdP     = 1'b0;
        clrP    = 1'b0;
        decB    = 1'b0;
        case (r_state)
            S_LOAD_A: begin
                data_in = r_opa;
                LdA     = !abort;
            end
            S_LOAD_B: begin
                data_in = r_opb;
                LdB     = !abort;
                clrP    = !abort;
            end
            S_ADD: begin
                LdP  = !abort && !eqz;
                decB = !abort && !eqz;
            end
            default: ;
        endcase
    end

    assign req_ready = rst_n && (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign res_valid = (r_state == S_DONE);
    assign iter_cnt  = r_iter;

endmodule

// File: tb/tb_mul_ctrl.sv
// Scoreboard bench for mul_ctrl: a behavioural datapath (A, B counter, P) closes
// the loop, and expected products come from plain multiplication.
module tb_mul_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         abort = 1'b0;
    logic         eqz;
    logic [W-1:0] data_in;
    logic         LdA, LdB, LdP, clrP, decB;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic         busy;
    logic [W-1:0] iter_cnt;

    mul_ctrl #(.W(W), .SWAP_MIN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .abort(abort), .eqz(eqz), .data_in(data_in),
        .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrP(clrP), .decB(decB),
        .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    logic [W-1:0] dp_a = '0;
    logic [W-1:0] dp_b = '0;
    logic [W-1:0] dp_p = '0;
    always @(posedge clk) begin
        if (LdA) dp_a <= data_in;
        if (LdB) dp_b <= data_in;
        else if (decB) dp_b <= dp_b - 1'b1;
        if (clrP) dp_p <= '0;
        else if (LdP) dp_p <= dp_p + dp_a;
    end
    assign eqz = (dp_b == '0);

    typedef struct {
        logic [W-1:0] opa;
        logic [W-1:0] opb;
        logic [W-1:0] prod;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           acc_cyc = 0;
    int           ldp_n = 0;
    logic         prev_rv = 1'b0;
    logic [W-1:0] held_p = '0;
    exp_t         e_mon;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rv = 1'b0;
        end else begin
            chk("ready_vs_busy", req_ready, !busy);
            chk("ldp_decb_pair", LdP, decB);
            if (LdA) begin
                if (sb.size() == 0) chk("lda_unexpected", 1, 0);
                else chk("lda_data", data_in, sb[0].opa);
            end
            if (LdB) begin
                if (sb.size() == 0) chk("ldb_unexpected", 1, 0);
                else chk("ldb_data", data_in, sb[0].opb);
                chk("ldb_clrp", clrP, 1);
            end else begin
                chk("clrp_alone", clrP, 0);
            end
            if (LdP) ldp_n++;
            if (!busy || res_valid) begin
                chk("data_in_zero", data_in, 0);
                chk("strobes_zero", {LdA, LdB, LdP, clrP, decB}, 0);
            end
            if (abort && busy && !res_valid) begin
                chk("abort_strobes", {LdA, LdB, LdP, clrP, decB}, 0);
                if (sb.size() != 0) void'(sb.pop_front());
            end
            if (res_valid && !prev_rv) begin
                if (sb.size() == 0) begin
                    chk("res_valid_unexpected", 1, 0);
                end else begin
                    e_mon = sb.pop_front();
                    chk("product", dp_p, e_mon.prod);
                    chk("iter_cnt", iter_cnt, e_mon.opb);
                    chk("latency", cyc - acc_cyc, 3 + int'(e_mon.opb));
                    chk("ldp_pulses", ldp_n, e_mon.opb);
                end
                held_p = dp_p;
            end else if (res_valid) begin
                chk("p_hold", dp_p, held_p);
            end
            if (req_valid && req_ready) begin
                acc_cyc = cyc + 1;
                ldp_n   = 0;
            end
            prev_rv = res_valid;
        end
    end

    // abort_n < 0: run to completion; otherwise assert abort abort_n cycles after LOAD_A.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int abort_n, input int hold);
        exp_t        e;
        logic [31:0] full;
        int          n;
        full   = 32'(a) * 32'(b);
        e.opa  = (a < b) ? b : a;
        e.opb  = (a < b) ? a : b;
        e.prod = full[W-1:0];
        @(posedge clk); #1;
        req_a = a; req_b = b; req_valid = 1'b1;
        res_ready = (hold == 0);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (abort_n >= 0) begin
            repeat (abort_n) begin @(posedge clk); #1; end
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            chk("abort_to_idle", busy, 0);
            chk("abort_no_valid", res_valid, 0);
        end else begin
            n = 0;
            while (!res_valid && n < 400) begin @(posedge clk); #1; n++; end
            if (!res_valid) chk("res_valid_timeout", 0, 1);
            repeat (hold) begin
                chk("bp_valid", res_valid, 1);
                chk("bp_ready", req_ready, 0);
                req_valid = 1'b1; req_a = W'($urandom); req_b = W'($urandom);
                @(posedge clk); #1;
                req_valid = 1'b0;
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            chk("back_to_idle", busy, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_data", data_in, 0);
        chk("rst_iter", iter_cnt, 0);
        chk("rst_strobes", {LdA, LdB, LdP, clrP, decB}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", req_ready, 1);

        do_op(16'd7, 16'd5, -1, 0);
        do_op(16'd3, 16'd200, -1, 0);
        do_op(16'd9, 16'd0, -1, 0);
        do_op(16'd4, 16'd10, 4, 0);
        do_op(16'd6, 16'd6, -1, 0);
        do_op(16'd11, 16'd4, -1, 10);

        // Asynchronous reset in the middle of ADD, between clock edges.
        @(posedge clk); #1;
        req_a = 16'd20; req_b = 16'd30; req_valid = 1'b1;
        sb.push_back('{opa: 16'd30, opb: 16'd20, prod: 16'd600});
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", res_valid, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_data", data_in, 0);
        chk("arst_iter", iter_cnt, 0);
        chk("arst_strobes", {LdA, LdB, LdP, clrP, decB}, 0);
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_ready_release", req_ready, 1);
        do_op(16'd2, 16'd3, -1, 0);

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb, mn;
            int           ab;
            ra = W'($urandom);
            rb = W'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                mn = ra; ra = rb; rb = mn;
            end
            mn = (ra < rb) ? ra : rb;
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2 + int'(mn))) : -1;
            do_op(ra, rb, ab, int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_ctrl.md
# mul_ctrl

Control sequencer for the repeated-addition multiplier. It accepts operand pairs from upstream over a valid/ready handshake and serialises them onto the shared `data_in` bus. It drives the datapath strobes `LdA`, `LdB`, `LdP`, `clrP` and `decB`, watches `eqz`, and holds a result-valid handshake until downstream reads the product from the datapath P register.

## Interface
- `W`, default 16: operand width; must match the datapath bus width.
- `SWAP_MIN`, default 1: when 1, the operands are swapped so the smaller one is loaded into the B counter, minimising iterations.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: an operand pair is presented.
- `req_ready`, out, 1: the block can accept a pair.
- `req_a`, in, W: multiplicand.
- `req_b`, in, W: multiplier.
- `abort`, in, 1: synchronous cancel of the operation in flight.
- `eqz`, in, 1: datapath B counter is zero (combinational from the B register).
- `data_in`, out, W: operand bus to the datapath.
- `LdA`, `LdB`, `LdP`, `clrP`, `decB`, out, 1 each: datapath strobes, sampled by the datapath at the same `clk` edge.
- `res_valid`, out, 1: the product in datapath P is final.
- `res_ready`, in, 1: downstream has taken the product.
- `busy`, out, 1: high in every state except IDLE.
- `iter_cnt`, out, W: number of add cycles performed for the current or last operation.

## Operation
- States: IDLE, LOAD_A, LOAD_B, ADD, DONE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&`req_ready`, capture the operands into internal registers `opa`/`opb`.
    - If `SWAP_MIN`=1 and `req_a`<`req_b` (unsigned), capture `opa`=`req_b` and `opb`=`req_a`.
  - Clear `iter_cnt`, then go to LOAD_A.
- **LOAD_A**: `data_in`=`opa`, `LdA`=1; go to LOAD_B.
- **LOAD_B**: `data_in`=`opb`, `LdB`=1, `clrP`=1; go to ADD.
- **ADD**
  - If `eqz`=0: `LdP`=1, `decB`=1, `iter_cnt`+=1; stay in ADD.
  - If `eqz`=1: no strobes; go to DONE.
- **DONE**: `res_valid`=1; when `res_ready`=1, go to IDLE.
- All strobes are Moore or Mealy outputs decoded from state and `eqz`. All strobes are 0 in IDLE and DONE.
- `data_in`=0 in every state other than LOAD_A and LOAD_B.
- Arithmetic:
  - `iter_cnt` wraps modulo 2^W; it cannot wrap in practice because `iter_cnt` ≤ `opb`.
  - The product is modulo 2^W, because the datapath truncates. The block makes no overflow indication.
- `abort`:
  - In LOAD_A, LOAD_B or ADD: next state is IDLE, all strobes are 0 in that cycle, and `res_valid` never asserts. `abort` takes priority over `eqz`.
  - In IDLE or DONE: `abort` is ignored.
- `req_valid` outside IDLE is ignored; `req_ready`=0 there.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State goes to IDLE.
  - `opa`, `opb` and `iter_cnt` go to 0.
  - `res_valid`, `busy` and all strobes are 0; `data_in`=0.
  - `req_ready` is forced to 0 while `rst_n`=0 and is 1 from the first cycle after release.
- Reset asserted mid-operation returns to IDLE immediately. The datapath registers are not cleared by this block; the next `clrP` reinitialises P.
- Latency from the accept edge to `res_valid`=1 is 3 + `opb` cycles: LOAD_A, LOAD_B, `opb` add cycles, one `eqz` cycle, then DONE.
- Back-to-back throughput: a new request can be accepted in the cycle after DONE exits.
- `res_valid` stays high and P stays stable until `res_ready`. There is no combinational path from `res_ready` to `req_ready`.

## Test plan
- **Basic:** `req_a`=7, `req_b`=5, `SWAP_MIN`=0. Required: `LdA` one cycle with `data_in`=7, then `LdB`+`clrP` with `data_in`=5, then exactly 5 cycles of `LdP`+`decB`, `res_valid` 8 cycles after accept, P=35, `iter_cnt`=5.
- **Swap:** `req_a`=3, `req_b`=200, `SWAP_MIN`=1. Required: `data_in`=200 on `LdA`, 3 on `LdB`, `iter_cnt`=3, P=600.
- **Zero multiplier:** `req_a`=9, `req_b`=0. Required: no `LdP` pulses, `res_valid` 3 cycles after accept, P=0 (cleared by `clrP`).
- **Abort:** `req_a`=4, `req_b`=10, `abort` in the 3rd ADD cycle. Required: strobes stop that cycle, state returns to IDLE, no `res_valid`, and the next request 6×6 returns 36.
- **Backpressure:** hold `res_ready`=0 for 10 cycles in DONE. Required: `res_valid` stays 1, no strobes, `req_ready`=0, and `req_valid` pulses are ignored.
- **Async reset:** pull `rst_n` low mid-ADD between clock edges. Required: outputs go to their reset values immediately, `req_ready` goes to 1 on the first cycle after release, and a following 2×3 request gives 6.
